// File: rtl/mult_div_pkg.sv
// Shared widths, funct encodings and FSM states for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam int DATA_W   = 32;
  localparam int DOUBLE_W = 2 * DATA_W;
  localparam int FUNCT_W  = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1a;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, which reads correctly as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] value,
                                                  input logic             signed_op);
    return (signed_op && value[DATA_W-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module mult_div_step
  import mult_div_pkg::*;
(
  input  logic [DOUBLE_W-1:0] acc,
  input  logic [DATA_W-1:0]   operand,
  input  logic                is_div,
  output logic [DOUBLE_W-1:0] acc_next
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    sum      = {1'b0, acc[DOUBLE_W-1:DATA_W]} + {1'b0, operand};
    shifted  = {acc[DOUBLE_W-1:DATA_W], acc[DATA_W-1]};
    diff     = shifted - {1'b0, operand};
    acc_next = acc;
    if (is_div) begin
      // A set sign bit on the 33-bit trial difference means the divisor did not fit.
      if (!diff[DATA_W]) acc_next = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else               acc_next = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[DATA_W-1:1]};
    end else begin
      acc_next = {1'b0, acc[DOUBLE_W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU unit for the EX stage; result is HI:LO with a done flag.
module mult_div
  import mult_div_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [DATA_W-1:0]   operand_1,
  input  logic [DATA_W-1:0]   operand_2,
  input  logic                pipeline_hold,
  input  logic                flush,
  output logic                mult_div_done,
  output logic [DOUBLE_W-1:0] mult_div_result,
  output logic                mult_div_busy
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  md_state_e           state;
  logic [CNT_W-1:0]    count;
  logic [DOUBLE_W-1:0] acc;
  logic [DOUBLE_W-1:0] acc_next;
  logic [DATA_W-1:0]   operand;
  logic                is_div;
  logic                neg_res;
  logic                neg_rem;

  logic                md_op;
  logic                op_is_div;
  logic                is_signed;
  logic [DATA_W-1:0]   mag_1;
  logic [DATA_W-1:0]   mag_2;
  logic [DOUBLE_W-1:0] fixed_result;

  assign md_op     = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                     (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign op_is_div = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign is_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign mag_1     = magnitude(operand_1, is_signed);
  assign mag_2     = magnitude(operand_2, is_signed);

  mult_div_step u_step (
    .acc      (acc),
    .operand  (operand),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  // Sign fix on the final iteration's output: full 64-bit negate for multiply, per-half for divide.
  always_comb begin
    fixed_result = neg_res ? -acc_next : acc_next;
    if (is_div) begin
      fixed_result[DOUBLE_W-1:DATA_W] = neg_rem ? -acc_next[DOUBLE_W-1:DATA_W]
                                                : acc_next[DOUBLE_W-1:DATA_W];
      fixed_result[DATA_W-1:0]        = neg_res ? -acc_next[DATA_W-1:0]
                                                : acc_next[DATA_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= MD_IDLE;
      count           <= '0;
      acc             <= '0;
      operand         <= '0;
      is_div          <= 1'b0;
      neg_res         <= 1'b0;
      neg_rem         <= 1'b0;
      mult_div_done   <= 1'b0;
      mult_div_result <= '0;
    end else if (flush) begin
      state         <= MD_IDLE;
      mult_div_done <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_op) begin
            if (op_is_div && (operand_2 == '0)) begin
              state           <= MD_DONE;
              mult_div_done   <= 1'b1;
              mult_div_result <= {operand_1, {DATA_W{1'b1}}};
            end else begin
              state   <= MD_BUSY;
              count   <= '0;
              is_div  <= op_is_div;
              operand <= op_is_div ? mag_2 : mag_1;
              acc     <= {{DATA_W{1'b0}}, op_is_div ? mag_1 : mag_2};
              neg_res <= is_signed & (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
              neg_rem <= is_signed & operand_1[DATA_W-1];
            end
          end
        end
        MD_BUSY: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state           <= MD_DONE;
            mult_div_done   <= 1'b1;
            mult_div_result <= fixed_result;
          end
        end
        MD_DONE: begin
          // Holding here keeps the still-present EX instruction from being restarted.
          if (!pipeline_hold) begin
            state         <= MD_IDLE;
            mult_div_done <= 1'b0;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign mult_div_busy = (state == MD_BUSY);

endmodule
